// File: rtl/jt89_mixer_n.sv
// Multi-channel gain/mute mixer with a cascaded one-pole low-pass filter on the mix.
// Define JT89_MIXER_SAT_EN to saturate the mix into the filter range; otherwise it wraps.
module jt89_mixer_n #(
    parameter int CHN    = 4,
    parameter int IW     = 10,
    parameter int OW     = 12,
    parameter int STAGES = 3,
    parameter int GW     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cen,
    input  logic [CHN*IW-1:0]     ch,
    input  logic [CHN*GW-1:0]     gain,
    input  logic [CHN-1:0]        mute,
    output logic signed [OW-1:0]  sound,
    output logic                  sample_valid
);
    localparam int FW   = OW + 1;
    localparam int IDXW = $clog2(CHN);
    localparam int AW   = IW + GW + IDXW + 1;
    localparam int PW   = IW + GW + 1;
    localparam int XW   = (AW > FW) ? AW : FW;

    typedef enum logic [1:0] {IDLE, ACC, FILT} state_t;

    state_t                 state_reg, state_next;
    logic [IDXW-1:0]        idx_reg, idx_next;
    logic signed [AW-1:0]   acc_reg, acc_next;
    logic signed [FW-1:0]   s_reg  [STAGES];
    logic signed [FW-1:0]   s_next [STAGES];
    logic signed [PW-1:0]   term   [CHN];
    logic signed [PW-1:0]   cur_term;
    logic signed [XW-1:0]   acc_x;
    logic signed [FW-1:0]   fresh;
    logic                   do_filt;

    // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
    for (genvar gi = 0; gi < CHN; gi++) begin : g_term
        logic signed [IW-1:0] x;
        logic signed [PW-1:0] prod;
        assign x       = ch[gi*IW +: IW];
        assign prod    = x * $signed({1'b0, gain[gi*GW +: GW]});
        assign term[gi] = mute[gi] ? '0 : (prod >>> 2);
    end

    assign cur_term = term[idx_reg];

    if (XW > AW) begin : g_ext
        assign acc_x = {{(XW-AW){acc_reg[AW-1]}}, acc_reg};
    end else begin : g_noext
        assign acc_x = acc_reg;
    end

`ifdef JT89_MIXER_SAT_EN
    localparam logic signed [XW-1:0] FMAX = {{(XW-FW+1){1'b0}}, {(FW-1){1'b1}}};
    localparam logic signed [XW-1:0] FMIN = {{(XW-FW+1){1'b1}}, {(FW-1){1'b0}}};
    always_comb begin
        fresh = acc_x[FW-1:0];
        if (acc_x > FMAX)
            fresh = FMAX[FW-1:0];
        else if (acc_x < FMIN)
            fresh = FMIN[FW-1:0];
    end
`else
    assign fresh = acc_x[FW-1:0];
`endif

    // Each stage averages itself with its upstream neighbour; the last stage takes the fresh mix.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic signed [FW-1:0] upstream;
        logic signed [FW:0]   sum;
        if (gi == STAGES-1) begin : g_last
            assign upstream = fresh;
        end else begin : g_mid
            assign upstream = s_reg[gi+1];
        end
        assign sum        = {s_reg[gi][FW-1], s_reg[gi]} + {upstream[FW-1], upstream};
        assign s_next[gi] = sum[FW:1];
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        acc_next   = acc_reg;
        do_filt    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cen) begin
                    state_next = ACC;
                    idx_next   = '0;
                    acc_next   = '0;
                end
            end
            ACC: begin
                if (cen) begin
                    acc_next = acc_reg + {{(AW-PW){cur_term[PW-1]}}, cur_term};
                    if (idx_reg == IDXW'(CHN-1)) begin
                        idx_next   = '0;
                        state_next = FILT;
                    end else begin
                        idx_next = idx_reg + IDXW'(1);
                    end
                end
            end
            FILT: begin
                do_filt    = 1'b1;
                acc_next   = '0;
                idx_next   = '0;
                state_next = ACC;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            acc_reg      <= '0;
            sound        <= '0;
            sample_valid <= 1'b0;
            for (int i = 0; i < STAGES; i++)
                s_reg[i] <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            acc_reg      <= acc_next;
            sample_valid <= do_filt;
            if (do_filt) begin
                for (int i = 0; i < STAGES; i++)
                    s_reg[i] <= s_next[i];
                sound <= s_next[0][FW-1:1];
            end
        end
    end
endmodule
